// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - front-panel, live-time and control buses of clock_mode_ctrl
// master drives buttons, 1 Hz tick and BCD time; slave is the controller.
interface clock_mode_ctrl_if;
  logic       tick_1Hz;
  logic       btn_mode;
  logic       btn_hr;
  logic       btn_min;
  logic       btn_arm;
  logic       btn_snooze;
  logic [3:0] sec_10s;
  logic [3:0] sec_1s;
  logic [3:0] min_10s;
  logic [3:0] min_1s;
  logic [3:0] hr_10s;
  logic [3:0] hr_1s;
  logic [3:0] al_min_10s;
  logic [3:0] al_min_1s;
  logic [3:0] al_hr_10s;
  logic [3:0] al_hr_1s;
  logic       tick_hr;
  logic       tick_min;
  logic       set_alarm;
  logic [1:0] mode;
  logic       armed;
  logic       buzzer;
  logic       snoozing;

  modport master (
    output tick_1Hz, btn_mode, btn_hr, btn_min, btn_arm, btn_snooze,
    output sec_10s, sec_1s, min_10s, min_1s, hr_10s, hr_1s,
    output al_min_10s, al_min_1s, al_hr_10s, al_hr_1s,
    input  tick_hr, tick_min, set_alarm, mode, armed, buzzer, snoozing
  );

  modport slave (
    input  tick_1Hz, btn_mode, btn_hr, btn_min, btn_arm, btn_snooze,
    input  sec_10s, sec_1s, min_10s, min_1s, hr_10s, hr_1s,
    input  al_min_10s, al_min_1s, al_hr_10s, al_hr_1s,
    output tick_hr, tick_min, set_alarm, mode, armed, buzzer, snoozing
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - mode FSM, held increment requests and alarm/buzzer control for the binary clock
// Define CLOCK_CTRL_SNOOZE_EN to include the SNOOZED state; otherwise the snooze button stops the alarm.
module clock_mode_ctrl #(
  parameter int TIMEOUT_S  = 10,
  parameter int RING_S     = 60,
`ifdef CLOCK_CTRL_SNOOZE_EN
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3,
`endif
  parameter int HOLD_CYC   = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  clock_mode_ctrl_if.slave io
);

  localparam int BM = 0;
  localparam int BH = 1;
  localparam int BN = 2;
  localparam int BA = 3;
  localparam int BS = 4;
  localparam int TO_W   = $clog2(TIMEOUT_S + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
`ifdef CLOCK_CTRL_SNOOZE_EN
  localparam int CNT_MAX = (SNOOZE_S > RING_S) ? SNOOZE_S : RING_S;
  localparam int SNZ_W   = $clog2(MAX_SNOOZE + 1);
`else
  localparam int CNT_MAX = RING_S;
`endif
  localparam int AL_W = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

`ifdef CLOCK_CTRL_SNOOZE_EN
  typedef enum logic [1:0] {AL_IDLE = 2'd0, AL_RING = 2'd1, AL_SNOOZE = 2'd2} al_e;
`else
  typedef enum logic [1:0] {AL_IDLE = 2'd0, AL_RING = 2'd1} al_e;
`endif

  logic [4:0]             btn_lvl;
  logic [4:0]             btn_prev_q, btn_prev_d;
  logic [4:0]             btn_stb_q, btn_stb_d;
  logic                   tick_prev_q, tick_prev_d;
  logic                   sec_tick_q, sec_tick_d;
  mode_e                  mode_q, mode_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [1:0]             pend_q, pend_d;
  logic [1:0][HOLD_W-1:0] hold_q, hold_d;
  logic                   armed_q, armed_d;
  al_e                    al_q, al_d;
  logic [AL_W-1:0]        al_cnt_q, al_cnt_d;
`ifdef CLOCK_CTRL_SNOOZE_EN
  logic [SNZ_W-1:0]       snz_cnt_q, snz_cnt_d;
`endif
  logic                   in_set, any_pend, mode_step, time_match;
  logic [1:0]             incr_stb;

  assign btn_lvl     = {io.btn_snooze, io.btn_arm, io.btn_min, io.btn_hr, io.btn_mode};
  assign btn_prev_d  = btn_lvl;
  assign btn_stb_d   = btn_lvl & ~btn_prev_q;
  assign tick_prev_d = io.tick_1Hz;
  assign sec_tick_d  = io.tick_1Hz & ~tick_prev_q;

  assign in_set    = (mode_q != MODE_RUN);
  assign any_pend  = |pend_q;
  // A held request pins the mode so set_alarm cannot move under it.
  assign mode_step = btn_stb_q[BM] & ~any_pend;
  assign incr_stb  = {btn_stb_q[BN], btn_stb_q[BH]} & {2{in_set & ~mode_step}};

  assign time_match = (io.sec_10s == 4'd0) && (io.sec_1s == 4'd0) &&
                      (io.hr_10s == io.al_hr_10s) && (io.hr_1s == io.al_hr_1s) &&
                      (io.min_10s == io.al_min_10s) && (io.min_1s == io.al_min_1s);

  always_comb begin
    mode_d   = mode_q;
    to_cnt_d = to_cnt_q;
    if (!in_set || (|btn_stb_q)) begin
      to_cnt_d = '0;
    end else if (sec_tick_q && to_cnt_q != TO_W'(TIMEOUT_S)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (mode_step) begin
      to_cnt_d = '0;
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_TIME;
        MODE_SET_TIME: mode_d = MODE_SET_ALARM;
        default:       mode_d = MODE_RUN;
      endcase
    end else if (in_set && !any_pend && to_cnt_d == TO_W'(TIMEOUT_S)) begin
      // Counter saturates, so an expiry held off by a pending request fires once it clears.
      mode_d   = MODE_RUN;
      to_cnt_d = '0;
    end
  end

  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    for (int i = 0; i < 2; i++) begin
      if (incr_stb[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
      end else if (pend_q[i]) begin
        if (hold_q[i] != '0) begin
          if (hold_q[i] == HOLD_W'(HOLD_CYC - 1)) begin
            pend_d[i] = 1'b0;
            hold_d[i] = '0;
          end else begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
          end
        end else if (sec_tick_q) begin
          hold_d[i] = HOLD_W'(1);
        end
      end
    end
  end

  always_comb begin
    armed_d  = armed_q ^ btn_stb_q[BA];
    al_d     = al_q;
    al_cnt_d = al_cnt_q;
`ifdef CLOCK_CTRL_SNOOZE_EN
    snz_cnt_d = snz_cnt_q;
`endif
    if (btn_stb_q[BA] && armed_q) begin
      al_d     = AL_IDLE;
      al_cnt_d = '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
      snz_cnt_d = '0;
`endif
    end else begin
      case (al_q)
        AL_IDLE: begin
          if (sec_tick_q && armed_q && mode_q != MODE_SET_ALARM && time_match) begin
            al_d     = AL_RING;
            al_cnt_d = '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
            snz_cnt_d = '0;
`endif
          end
        end
        AL_RING: begin
          if (btn_stb_q[BS]) begin
            al_cnt_d = '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
            if (snz_cnt_q < SNZ_W'(MAX_SNOOZE)) begin
              al_d      = AL_SNOOZE;
              snz_cnt_d = snz_cnt_q + SNZ_W'(1);
            end else begin
              al_d = AL_IDLE;
            end
`else
            al_d = AL_IDLE;
`endif
          end else if (sec_tick_q) begin
            if (al_cnt_q == AL_W'(RING_S - 1)) begin
              al_d     = AL_IDLE;
              al_cnt_d = '0;
            end else begin
              al_cnt_d = al_cnt_q + AL_W'(1);
            end
          end
        end
`ifdef CLOCK_CTRL_SNOOZE_EN
        AL_SNOOZE: begin
          if (sec_tick_q) begin
            if (al_cnt_q == AL_W'(SNOOZE_S - 1)) begin
              al_d     = AL_RING;
              al_cnt_d = '0;
            end else begin
              al_cnt_d = al_cnt_q + AL_W'(1);
            end
          end
        end
`endif
        default: begin
          al_d     = AL_IDLE;
          al_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      btn_prev_q  <= '0;
      btn_stb_q   <= '0;
      tick_prev_q <= 1'b0;
      sec_tick_q  <= 1'b0;
      mode_q      <= MODE_RUN;
      to_cnt_q    <= '0;
      pend_q      <= '0;
      hold_q      <= '0;
      armed_q     <= 1'b0;
      al_q        <= AL_IDLE;
      al_cnt_q    <= '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
      snz_cnt_q   <= '0;
`endif
    end else begin
      btn_prev_q  <= btn_prev_d;
      btn_stb_q   <= btn_stb_d;
      tick_prev_q <= tick_prev_d;
      sec_tick_q  <= sec_tick_d;
      mode_q      <= mode_d;
      to_cnt_q    <= to_cnt_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      armed_q     <= armed_d;
      al_q        <= al_d;
      al_cnt_q    <= al_cnt_d;
`ifdef CLOCK_CTRL_SNOOZE_EN
      snz_cnt_q   <= snz_cnt_d;
`endif
    end
  end

  assign io.tick_hr   = pend_q[0];
  assign io.tick_min  = pend_q[1];
  assign io.set_alarm = (mode_q == MODE_SET_ALARM);
  assign io.mode      = mode_q;
  assign io.armed     = armed_q;
  assign io.buzzer    = (al_q == AL_RING);
`ifdef CLOCK_CTRL_SNOOZE_EN
  assign io.snoozing  = (al_q == AL_SNOOZE);
`else
  assign io.snoozing  = 1'b0;
`endif

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - self-checking bench for clock_mode_ctrl
// Randomised timing and settings; expectations come from the mode/alarm rules, tracked as plain integers.
module tb_clock_mode_ctrl;
  localparam int HOLD_CYC   = 8;
  localparam int TIMEOUT_S  = 10;
  localparam int RING_S     = 60;
  localparam int SNOOZE_S   = 300;
  localparam int MAX_SNOOZE = 3;
  localparam logic [4:0] B_MODE = 5'b00001;
  localparam logic [4:0] B_HR   = 5'b00010;
  localparam logic [4:0] B_MIN  = 5'b00100;
  localparam logic [4:0] B_ARM  = 5'b01000;
  localparam logic [4:0] B_SNZ  = 5'b10000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_mode = 0;
  int   al_h, al_m;

  always #5 clk = ~clk;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .io        (bus)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_btns(input logic [4:0] m);
    bus.btn_mode   = m[0];
    bus.btn_hr     = m[1];
    bus.btn_min    = m[2];
    bus.btn_arm    = m[3];
    bus.btn_snooze = m[4];
  endtask

  // Level high for one cycle; the effect is visible once this returns.
  task automatic press(input logic [4:0] m);
    drive_btns(m);
    cyc(1);
    drive_btns(5'b0);
    cyc(1);
  endtask

  task automatic sec_pulse();
    bus.tick_1Hz = 1'b1;
    cyc(2);
    bus.tick_1Hz = 1'b0;
    cyc(1);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.hr_10s  = 4'(h / 10);
    bus.hr_1s   = 4'(h % 10);
    bus.min_10s = 4'(m / 10);
    bus.min_1s  = 4'(m % 10);
    bus.sec_10s = 4'(s / 10);
    bus.sec_1s  = 4'(s % 10);
  endtask

  task automatic set_alarm_regs(input int h, input int m);
    bus.al_hr_10s  = 4'(h / 10);
    bus.al_hr_1s   = 4'(h % 10);
    bus.al_min_10s = 4'(m / 10);
    bus.al_min_1s  = 4'(m % 10);
  endtask

  task automatic step_mode();
    press(B_MODE);
    exp_mode = (exp_mode + 1) % 3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tick_1Hz = 1'b0;
    drive_btns(5'b0);
    set_time(12, 34, 56);
    set_alarm_regs(7, 15);
    cyc(3);
    total++;
    if ({bus.mode, bus.set_alarm, bus.tick_hr, bus.tick_min, bus.armed, bus.buzzer, bus.snoozing} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {bus.mode, bus.set_alarm, bus.tick_hr, bus.tick_min, bus.armed, bus.buzzer, bus.snoozing});
    end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_mode_seq();
    for (int i = 1; i <= 3; i++) begin
      step_mode();
      total++;
      if (bus.mode !== 2'(exp_mode) || bus.set_alarm !== (exp_mode == 2)) begin
        bad++;
        $display("FAIL mode_seq[%0d]: got mode=%0d set_alarm=%0d want mode=%0d set_alarm=%0d",
                 i, bus.mode, bus.set_alarm, exp_mode, exp_mode == 2);
      end
    end
  endtask

  task automatic test_mode_random();
    int n;
    n = $urandom_range(4, 10);
    for (int i = 0; i < n; i++) begin
      cyc($urandom_range(0, 4));
      step_mode();
      total++;
      if (bus.mode !== 2'(exp_mode) || bus.set_alarm !== (exp_mode == 2)) begin
        bad++;
        $display("FAIL mode_random[%0d]: got mode=%0d want %0d", i, bus.mode, exp_mode);
      end
    end
    while (exp_mode != 0) step_mode();
    total++;
    if (bus.mode !== 2'd0) begin
      bad++;
      $display("FAIL mode_wrap: got %0d want 0", bus.mode);
    end
  endtask

  task automatic test_hold();
    int hi;
    step_mode();
    cyc($urandom_range(0, 5));
    press(B_MIN);
    total++;
    if (bus.tick_min !== 1'b1 || bus.tick_hr !== 1'b0 || bus.set_alarm !== 1'b0) begin
      bad++;
      $display("FAIL hold_assert: got tick_min=%0d tick_hr=%0d set_alarm=%0d want 1 0 0",
               bus.tick_min, bus.tick_hr, bus.set_alarm);
    end
    cyc($urandom_range(0, 6));
    press(B_MIN);
    cyc($urandom_range(0, 6));
    bus.tick_1Hz = 1'b1;
    cyc(1);
    hi = 0;
    for (int k = 0; k < HOLD_CYC; k++) begin
      if (bus.tick_min === 1'b1) hi++;
      cyc(1);
    end
    bus.tick_1Hz = 1'b0;
    total++;
    if (hi != HOLD_CYC || bus.tick_min !== 1'b0) begin
      bad++;
      $display("FAIL hold_window: got high=%0d end=%0d want high=%0d end=0", hi, bus.tick_min, HOLD_CYC);
    end
  endtask

  task automatic test_simultaneous();
    press(B_HR | B_MIN);
    total++;
    if (bus.tick_hr !== 1'b1 || bus.tick_min !== 1'b1) begin
      bad++;
      $display("FAIL both_incr: got hr=%0d min=%0d want 1 1", bus.tick_hr, bus.tick_min);
    end
    sec_pulse();
    cyc(HOLD_CYC);
    total++;
    if (bus.tick_hr !== 1'b0 || bus.tick_min !== 1'b0) begin
      bad++;
      $display("FAIL both_release: got hr=%0d min=%0d want 0 0", bus.tick_hr, bus.tick_min);
    end
    press(B_MODE | B_HR);
    exp_mode = 2;
    total++;
    if (bus.mode !== 2'd2 || bus.tick_hr !== 1'b0) begin
      bad++;
      $display("FAIL mode_beats_incr: got mode=%0d tick_hr=%0d want 2 0", bus.mode, bus.tick_hr);
    end
  endtask

  task automatic test_lockout();
    press(B_HR);
    press(B_MODE);
    total++;
    if (bus.mode !== 2'd2 || bus.tick_hr !== 1'b1 || bus.set_alarm !== 1'b1) begin
      bad++;
      $display("FAIL lockout: got mode=%0d tick_hr=%0d want mode=2 tick_hr=1", bus.mode, bus.tick_hr);
    end
    sec_pulse();
    cyc(HOLD_CYC);
    step_mode();
    total++;
    if (bus.mode !== 2'(exp_mode)) begin
      bad++;
      $display("FAIL unlock_mode: got %0d want %0d", bus.mode, exp_mode);
    end
  endtask

  task automatic test_timeout();
    step_mode();
    step_mode();
    for (int i = 1; i <= TIMEOUT_S; i++) begin
      cyc($urandom_range(0, 3));
      sec_pulse();
      if (i == TIMEOUT_S - 1 || i == TIMEOUT_S) begin
        total++;
        if (bus.mode !== ((i == TIMEOUT_S) ? 2'd0 : 2'd2)) begin
          bad++;
          $display("FAIL timeout[%0d]: got %0d want %0d", i, bus.mode, (i == TIMEOUT_S) ? 0 : 2);
        end
      end
    end
    exp_mode = 0;
  endtask

  task automatic test_alarm();
    al_h = $urandom_range(0, 23);
    al_m = $urandom_range(0, 59);
    set_alarm_regs(al_h, al_m);
    set_time(al_h, al_m, 0);
    sec_pulse();
    total++;
    if (bus.buzzer !== 1'b0) begin
      bad++;
      $display("FAIL disarmed_no_ring: got %0d want 0", bus.buzzer);
    end
    press(B_ARM);
    total++;
    if (bus.armed !== 1'b1) begin
      bad++;
      $display("FAIL arm: got %0d want 1", bus.armed);
    end
    set_time(al_h, (al_m + 1) % 60, 0);
    sec_pulse();
    total++;
    if (bus.buzzer !== 1'b0) begin
      bad++;
      $display("FAIL mismatch_no_ring: got %0d want 0", bus.buzzer);
    end
    set_time(al_h, al_m, 0);
    bus.tick_1Hz = 1'b1;
    cyc(1);
    total++;
    if (bus.buzzer !== 1'b0) begin
      bad++;
      $display("FAIL ring_early: got %0d want 0", bus.buzzer);
    end
    cyc(1);
    total++;
    if (bus.buzzer !== 1'b1) begin
      bad++;
      $display("FAIL ring_start: got %0d want 1", bus.buzzer);
    end
    bus.tick_1Hz = 1'b0;
    cyc(1);
    set_time(al_h, al_m, 1);
    for (int i = 1; i <= RING_S; i++) begin
      sec_pulse();
      if (i >= RING_S - 1) begin
        total++;
        if (bus.buzzer !== (i < RING_S)) begin
          bad++;
          $display("FAIL ring_len[%0d]: got %0d want %0d", i, bus.buzzer, i < RING_S);
        end
      end
    end
  endtask

  task automatic test_snooze();
    set_time(al_h, al_m, 0);
    sec_pulse();
    set_time(al_h, al_m, 1);
    total++;
    if (bus.buzzer !== 1'b1) begin
      bad++;
      $display("FAIL snooze_ring: got %0d want 1", bus.buzzer);
    end
`ifdef CLOCK_CTRL_SNOOZE_EN
    for (int s = 1; s <= MAX_SNOOZE + 1; s++) begin
      press(B_SNZ);
      total++;
      if (bus.snoozing !== (s <= MAX_SNOOZE) || bus.buzzer !== 1'b0) begin
        bad++;
        $display("FAIL snooze_press[%0d]: got snoozing=%0d buzzer=%0d want %0d 0",
                 s, bus.snoozing, bus.buzzer, s <= MAX_SNOOZE);
      end
      if (s <= MAX_SNOOZE) begin
        repeat (SNOOZE_S - 1) sec_pulse();
        total++;
        if (bus.snoozing !== 1'b1 || bus.buzzer !== 1'b0) begin
          bad++;
          $display("FAIL snooze_hold[%0d]: got snoozing=%0d buzzer=%0d want 1 0", s, bus.snoozing, bus.buzzer);
        end
        sec_pulse();
        total++;
        if (bus.snoozing !== 1'b0 || bus.buzzer !== 1'b1) begin
          bad++;
          $display("FAIL snooze_rering[%0d]: got snoozing=%0d buzzer=%0d want 0 1", s, bus.snoozing, bus.buzzer);
        end
      end
    end
`else
    press(B_SNZ);
    sec_pulse();
    total++;
    if (bus.buzzer !== 1'b0 || bus.snoozing !== 1'b0) begin
      bad++;
      $display("FAIL stop: got buzzer=%0d snoozing=%0d want 0 0", bus.buzzer, bus.snoozing);
    end
`endif
  endtask

  task automatic test_disarm_race();
    set_time(al_h, al_m, 0);
    drive_btns(B_ARM);
    bus.tick_1Hz = 1'b1;
    cyc(1);
    drive_btns(5'b0);
    cyc(1);
    bus.tick_1Hz = 1'b0;
    cyc(1);
    total++;
    if (bus.armed !== 1'b0 || bus.buzzer !== 1'b0) begin
      bad++;
      $display("FAIL disarm_race: got armed=%0d buzzer=%0d want 0 0", bus.armed, bus.buzzer);
    end
    set_time(al_h, al_m, 1);
  endtask

  task automatic test_reset_mid_hold();
    step_mode();
    press(B_HR);
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus.tick_hr !== 1'b0 || bus.mode !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_hold: got tick_hr=%0d mode=%0d want 0 0", bus.tick_hr, bus.mode);
    end
    cyc(1);
    reset = 1'b0;
    exp_mode = 0;
    cyc(1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode_seq();
    test_mode_random();
    test_hold();
    test_simultaneous();
    test_lockout();
    test_timeout();
    test_alarm();
    test_snooze();
    test_disarm_race();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode and alarm controller for the binary clock datapath. Turns debounced front-panel button levels into the `tick_hr`, `tick_min` and `set_alarm` controls the clock counters expect, and enforces a RUN / SET_TIME / SET_ALARM mode sequence with an inactivity timeout. It also compares live time against the alarm setting and drives a buzzer with optional snooze. It sits between the button debouncers and the binary clock counter block, in the `clk_100MHz` domain.

## Interface
- `TIMEOUT_S`, 10: seconds without a button edge before a set mode returns to RUN.
- `RING_S`, 60: maximum ring duration in seconds.
- `SNOOZE_S`, 300: snooze interval in seconds.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event.
- `HOLD_CYC`, 8: `clk_100MHz` cycles an increment request is held after the qualifying 1 Hz edge.

Ports (clock and reset first):
- `clk_100MHz`  in  1  system clock. All logic is synchronous to its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick_1Hz`  in  1  1 Hz square wave from the clock block, same clock domain.
- `btn_mode`, `btn_hr`, `btn_min`, `btn_arm`, `btn_snooze`  in  1 each  debounced button levels.
- `sec_10s`, `sec_1s`, `min_10s`, `min_1s`, `hr_10s`, `hr_1s`  in  4 each  live BCD time.
- `al_min_10s`, `al_min_1s`, `al_hr_10s`, `al_hr_1s`  in  4 each  alarm BCD setting.
- `tick_hr`, `tick_min`  out  1  increment requests to the clock block.
- `set_alarm`  out  1  selects alarm registers as the increment target.
- `mode`  out  2  current mode: 0 = RUN, 1 = SET_TIME, 2 = SET_ALARM.
- `armed`  out  1  alarm enabled.
- `buzzer`  out  1  alarm sounding.
- `snoozing`  out  1  snooze interval active.

## Operation
- Buttons are rising-edge detected with one register stage; a press produces a 1-cycle internal strobe.
- `sec_tick` is a 1-cycle strobe on the rising edge of `tick_1Hz`.
- **Mode FSM:**
  - `btn_mode` edge steps RUN→SET_TIME→SET_ALARM→RUN.
  - `set_alarm` = 1 only in SET_ALARM.
  - In the set modes, a seconds counter clears on any button edge and increments on `sec_tick`. When it reaches `TIMEOUT_S`, the mode goes to RUN.
- **Increment requests:**
  - In SET_TIME or SET_ALARM, a `btn_hr` or `btn_min` edge sets the matching pending flag. The output is asserted the next cycle.
  - The output stays high until `HOLD_CYC` cycles after the next `sec_tick`, then clears. This guarantees exactly one 1 Hz sampling edge sees it.
  - Further edges on the same button while its flag is pending are ignored.
  - Button edges in RUN are ignored.
- **Mode-change lockout:** a `btn_mode` edge while either flag is pending is ignored, so `set_alarm` never changes under a held request. A timeout that expires while a flag is pending is deferred until the flag clears.
- **Arm:** `btn_arm` edge toggles `armed`. Disarming forces the alarm FSM to IDLE and clears the snooze count.
- **Alarm FSM (IDLE, RINGING, SNOOZED):**
  - IDLE→RINGING when all of these hold on a `sec_tick` cycle: `armed`, mode ≠ SET_ALARM, `sec_10s`=`sec_1s`=0, and hours and minutes equal the alarm setting. The snooze count clears on this transition.
  - RINGING: `buzzer`=1.
    - Goes to IDLE after `RING_S` ticks.
    - A `btn_snooze` edge goes to SNOOZED if count < `MAX_SNOOZE` (count increments), otherwise to IDLE.
  - SNOOZED: `snoozing`=1. Goes to RINGING after `SNOOZE_S` ticks.
  - The seconds counter is shared, reloads on each state entry and is wide enough for `SNOOZE_S`.
- **Simultaneous events:**
  - `btn_mode` and `btn_hr`/`btn_min` in the same cycle: mode wins, the increment is dropped.
  - `btn_hr` and `btn_min` in the same cycle: both are accepted.
  - `btn_arm` and an alarm match in the same cycle: the disarm wins.

## Timing
- Reset values: `mode`=0, `set_alarm`=0, `tick_hr`=`tick_min`=0, `armed`=0, `buzzer`=0, `snoozing`=0. All counters and flags are 0.
- Latencies:
  - Button level rise to output change: 2 cycles (edge register, then state register).
  - `tick_1Hz` rise to `sec_tick`: 1 cycle.
  - Alarm match to `buzzer`: 1 cycle after the `sec_tick` cycle.
- Reset asserted mid-operation clears everything asynchronously, including an in-flight increment request.

## Configuration
- `CLOCK_CTRL_SNOOZE_EN` defined: snooze behaves as described.
- Not defined:
  - The SNOOZED state and the snooze counter are removed; `snoozing` is tied to 0.
  - In RINGING, a `btn_snooze` edge goes directly to IDLE and acts as a stop.

## Test plan
- Reset, then `btn_mode` ×3 → `mode` 1, 2, 0; `set_alarm` high only at 2.
- SET_TIME, one `btn_min` press → `tick_min` high across exactly one `tick_1Hz` rise, low `HOLD_CYC`+1 cycles later; `set_alarm`=0.
- SET_ALARM, no presses for 10 ticks → `mode`=0 on the 10th `sec_tick`+1.
- `armed`=1, alarm 06:30, time steps to 06:30:00 → `buzzer`=1 one cycle later; after 60 ticks `buzzer`=0.
- Ringing with `CLOCK_CTRL_SNOOZE_EN`: `btn_snooze` → `snoozing`=1; 300 ticks later `buzzer`=1. The 4th snooze press → IDLE.
- `btn_hr` pending, `btn_mode` edge → `mode` unchanged; reset mid-hold → `tick_hr`=0 immediately.
